// File: rtl/reg_index_encoder_if.sv
// Handshake bundle for reg_index_encoder: vector request side and index stream side.
// REG_INDEX_ENCODER_EMPTY_ERR_EN adds the empty_err flag to the bundle.
interface reg_index_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] register;
  logic       last;
  logic [3:0] count;
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
  logic       empty_err;

  modport master (
    output req_valid, req_vec, out_ready,
    input  req_ready, out_valid, register, last, count, empty_err
  );
  modport slave (
    input  req_valid, req_vec, out_ready,
    output req_ready, out_valid, register, last, count, empty_err
  );
`else
  modport master (
    output req_valid, req_vec, out_ready,
    input  req_ready, out_valid, register, last, count
  );
  modport slave (
    input  req_valid, req_vec, out_ready,
    output req_ready, out_valid, register, last, count
  );
`endif
endinterface

// File: rtl/reg_index_encoder.sv
// Drains an 8-bit register-select vector (bit 7 = r0) into a stream of 3-bit indices, r0 first.
// Optional REG_INDEX_ENCODER_EMPTY_ERR_EN: one-cycle empty_err pulse after an accepted zero vector.
module reg_index_encoder (
  input  logic               clock,
  input  logic               reset_n,
  reg_index_encoder_if.slave bus
);
  localparam int unsigned N_REGS = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [N_REGS-1:0]   pending_q, pending_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    register_q, register_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [N_REGS-1:0]   clr_mask;
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
  logic                empty_err_q, empty_err_d;
`endif

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_REGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Highest set bit wins, since it maps to the lowest register number.
  function automatic logic [IDX_W-1:0] first_idx(input logic [N_REGS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (v[i]) idx = IDX_W'(N_REGS - 1 - i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    clr_mask  = {1'b1, {(N_REGS-1){1'b0}}} >> register_q;
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
    empty_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          pending_d = bus.req_vec;
          count_d   = popcnt(bus.req_vec);
          if (bus.req_vec != '0) begin
            state_d = DRAIN;
          end
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
          else begin
            empty_err_d = 1'b1;
          end
`endif
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          pending_d = pending_q & ~clr_mask;
          if (last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Output view is precomputed from the next pending so it is registered and bubble-free.
    out_valid_d = (state_d == DRAIN);
    register_d  = out_valid_d ? first_idx(pending_d) : '0;
    last_d      = out_valid_d && (popcnt(pending_d) == CNT_W'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      register_q  <= '0;
      last_q      <= 1'b0;
      count_q     <= '0;
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
      empty_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      register_q  <= register_d;
      last_q      <= last_d;
      count_q     <= count_d;
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
      empty_err_q <= empty_err_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.register  = register_q;
  assign bus.last      = last_q;
  assign bus.count     = count_q;
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
  assign bus.empty_err = empty_err_q;
`endif
endmodule

// File: tb/tb_reg_index_encoder.sv
// Directed bench for reg_index_encoder with hand-computed expected index streams.
module tb_reg_index_encoder;
  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  reg_index_encoder_if bus ();

  reg_index_encoder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] r, input logic l);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".register"},  32'(bus.register),  32'(r));
    check({tag, ".last"},      32'(bus.last),      32'(l));
  endtask

  // Present a vector for one edge; returns at the negedge after acceptance.
  task automatic send_vec(input logic [7:0] v);
    bus.req_valid = 1'b1;
    bus.req_vec   = v;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vec   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check_out("rst", 1'b0, 3'd0, 1'b0);
    check("rst.count", 32'(bus.count), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1010_0001 -> r0, r2, r7 with out_ready held high
    bus.out_ready = 1'b1;
    send_vec(8'b1010_0001);
    check_out("a1.0", 1'b1, 3'd0, 1'b0);
    check("a1.count", 32'(bus.count), 32'd3);
    check("a1.req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    check_out("a1.1", 1'b1, 3'd2, 1'b0);
    @(negedge clock);
    check_out("a1.2", 1'b1, 3'd7, 1'b1);
    @(negedge clock);
    check_out("a1.end", 1'b0, 3'd0, 1'b0);
    check("a1.end.req_ready", 32'(bus.req_ready), 32'd1);
    check("a1.end.count", 32'(bus.count), 32'd3);

    // FF with out_ready toggling: each index must hold through the stalled cycle
    bus.out_ready = 1'b0;
    send_vec(8'hFF);
    check("ff.count", 32'(bus.count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check_out($sformatf("ff.%0d", k), 1'b1, 3'(k), k == 7);
      @(negedge clock);
      check_out($sformatf("ff.hold%0d", k), 1'b1, 3'(k), k == 7);
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
    end
    check_out("ff.end", 1'b0, 3'd0, 1'b0);
    check("ff.end.req_ready", 32'(bus.req_ready), 32'd1);

    // Zero vector: consumed without output, count reloads to 0
    bus.out_ready = 1'b1;
    send_vec(8'h00);
    check_out("z", 1'b0, 3'd0, 1'b0);
    check("z.req_ready", 32'(bus.req_ready), 32'd1);
    check("z.count", 32'(bus.count), 32'd0);
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
    check("z.empty_err", 32'(bus.empty_err), 32'd1);
`endif
    @(negedge clock);
    check_out("z.after", 1'b0, 3'd0, 1'b0);
`ifdef REG_INDEX_ENCODER_EMPTY_ERR_EN
    check("z.empty_err_clr", 32'(bus.empty_err), 32'd0);
`endif

    // C0 while a 0F request is pending during DRAIN: the 0F must be ignored
    bus.out_ready = 1'b0;
    send_vec(8'hC0);
    bus.req_valid = 1'b1;
    bus.req_vec   = 8'h0F;
    check("c0.req_ready", 32'(bus.req_ready), 32'd0);
    check("c0.count", 32'(bus.count), 32'd2);
    check_out("c0.0", 1'b1, 3'd0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    check_out("c0.1", 1'b1, 3'd1, 1'b1);
    check("c0.1.count", 32'(bus.count), 32'd2);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check_out("c0.end", 1'b0, 3'd0, 1'b0);
    check("c0.end.req_ready", 32'(bus.req_ready), 32'd1);
    check("c0.end.count", 32'(bus.count), 32'd2);

    // F0 with reset mid-drain after the first transfer
    send_vec(8'hF0);
    check_out("f0.0", 1'b1, 3'd0, 1'b0);
    @(negedge clock);
    check_out("f0.1", 1'b1, 3'd1, 1'b0);
    reset_n = 1'b0;
    #1;
    check_out("f0.rst", 1'b0, 3'd0, 1'b0);
    check("f0.rst.count", 32'(bus.count), 32'd0);
    check("f0.rst.req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_out($sformatf("f0.post%0d", k), 1'b0, 3'd0, 1'b0);
      check($sformatf("f0.post%0d.req_ready", k), 32'(bus.req_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
